// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with a registered result and a sticky {S,Z,C,V} status.
// Single-cycle ops complete on the accept edge. The optional iterative multiplier
// (ALU_MUL_EN) adds one partial product per cycle in a BUSY state.
// Build option: define ALU_MUL_EN to build the multiplier. Without it, op 0110 is illegal.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [15:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [3:0]       code,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_MUL_EN
  localparam logic [1:0] BUSY = 2'd1;
`endif
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0110;
`endif
  localparam logic [3:0] OP_MOV = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  logic [1:0]     state;
  logic [3:0]     op;
  logic [SHW-1:0] shamt;

  // Only the op field matters; the rest of the instruction word belongs to other stages.
  logic unused_instr;
  assign unused_instr = ^{instr[15:8], instr[3:0]};

  assign op        = instr[7:4];
  assign shamt     = b[SHW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One extra bit on each side so the carry/borrow or the last bit shifted out
  // falls into a real bit position instead of needing separate logic.
  logic [WIDTH:0] sum_w, dif_w, sll_w, srl_w, sra_w;
  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} - {1'b0, b};
  assign sll_w = {1'b0, a} << shamt;
  assign srl_w = {a, 1'b0} >> shamt;
  assign sra_w = $signed({a, 1'b0}) >>> shamt;

  logic [WIDTH-1:0] res_x;
  logic             res_c, res_v, res_ill;

  // Single-cycle result and carry/overflow, selected by op.
  always_comb begin
    res_x   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (op)
      OP_ADD: begin
        res_x = sum_w[WIDTH-1:0];
        res_c = sum_w[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_x = dif_w[WIDTH-1:0];
        res_c = dif_w[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_x = a & b;
      OP_OR:  res_x = a | b;
      OP_XOR: res_x = a ^ b;
      OP_MOV: res_x = b;
      OP_SLL: begin
        res_x = sll_w[WIDTH-1:0];
        res_c = sll_w[WIDTH];
      end
      OP_SRL: begin
        res_x = srl_w[WIDTH:1];
        res_c = srl_w[0];
      end
      OP_SRA: begin
        res_x = sra_w[WIDTH:1];
        res_c = sra_w[0];
      end
      // MUL takes the BUSY path and never uses this result.
`ifdef ALU_MUL_EN
      OP_MUL: res_ill = 1'b0;
`endif
      default: res_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Shift-and-add multiplier: one partial product per BUSY cycle, LSB of b first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == IDLE && in_valid && op == OP_MUL) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= SHW'(WIDTH - 1);
    end else if (state == BUSY) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end
`endif

  // Control FSM; x, code and err are only written on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      code  <= 4'b0000;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            state <= BUSY;
          end else
`endif
          begin
            state <= DONE;
            err   <= res_ill;
            if (res_ill) begin
              // Illegal op: zero result, status keeps its previous value.
              x <= '0;
            end else begin
              x    <= res_x;
              code <= {res_x[WIDTH-1], (res_x == '0), res_c, res_v};
            end
          end
        end
`ifdef ALU_MUL_EN
        BUSY: if (cnt == '0) begin
          state <= DONE;
          err   <= 1'b0;
          x     <= acc_nxt[WIDTH-1:0];
          code  <= {acc_nxt[WIDTH-1], (acc_nxt[WIDTH-1:0] == '0),
                    (acc_nxt[2*WIDTH-1:WIDTH] != '0), (acc_nxt[2*WIDTH-1:WIDTH] != '0)};
        end
`endif
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=16). Stimulus pushes model results,
// a monitor pops them on each output handshake and also checks latency.
module tb_alu_seq;
  localparam int W = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0]  a, b, x;
  logic [15:0]   instr;
  logic [3:0]    code;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .code(code), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [3:0]   code;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          bp_mode = 0;  // 0: always ready, 1: random, 2: driven by stimulus
  logic [3:0]  model_code = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the op definitions.
  task automatic push(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int sa, sb, r, n;
    longint p;
    logic [W-1:0] xr;
    bit c, v, ill;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    n = int'(bv[3:0]);
    xr = '0; c = 0; v = 0; ill = 0;
    case (op)
      4'd0: begin
        r = int'(av) + int'(bv);
        xr = r[W-1:0]; c = (r > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1, 4'd5: begin
        xr = av - bv; c = (av < bv);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2: xr = av & bv;
      4'd3: xr = av | bv;
      4'd4: xr = av ^ bv;
      4'd6: begin
        if (MUL_EN) begin
          p = longint'(av) * longint'(bv);
          xr = p[W-1:0]; c = (p > 65535); v = c;
        end else ill = 1;
      end
      4'd8: xr = bv;
      4'd9: begin
        xr = av << n; c = (n == 0) ? 1'b0 : av[16-n];
      end
      4'd10: begin
        xr = av >> n; c = (n == 0) ? 1'b0 : av[n-1];
      end
      4'd11: begin
        xr = W'($signed(av) >>> n); c = (n == 0) ? 1'b0 : av[n-1];
      end
      default: ill = 1;
    endcase
    e.err = ill;
    if (ill) begin
      e.x = '0;
      e.code = model_code;
    end else begin
      e.x = xr;
      e.code = {xr[W-1], (xr == 0), c, v};
      model_code = e.code;
    end
    e.lat = (op == 4'd6 && MUL_EN) ? W + 1 : 1;
    e.t0 = cyc;
    q.push_back(e);
  endtask

  // Present one transaction at a falling edge once in_ready is seen; scramble inputs after.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit track);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
    end else begin
      in_valid = 1'b1;
      instr = 16'($urandom());
      instr[7:4] = op;
      a = av;
      b = bv;
      if (track) push(op, av, bv);
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom());
      b = 16'($urandom());
      instr = 16'($urandom());
    end
  endtask

  // Consumer backpressure generator.
  initial forever begin
    @(negedge clk);
    if (bp_mode == 0) out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = 1'($urandom());
  end

  // Monitor: latency on each new result, data on each handshake.
  initial begin
    bit prev_ov = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_ov = 0;
      end else begin
        if (out_valid) check("ready_valid_exclusive", in_ready, 0);
        if (out_valid && !prev_ov && q.size() > 0)
          check("latency", cyc - q[0].t0, q[0].lat);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_result: got x=%0h expected no result", x);
          end else begin
            e = q.pop_front();
            check("x", x, e.x);
            check("code", code, e.code);
            check("err", err, e.err);
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin
    exp_t e;
    int t;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [6];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001; corner[5] = 16'h0100;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; instr = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x", x, 0);
    check("rst_code", code, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // Directed operations from the plan.
    issue(4'd0, 16'h7FFF, 16'h0001, 1);
    issue(4'd1, 16'h0000, 16'h0001, 1);
    issue(4'd5, 16'h0005, 16'h0005, 1);
    issue(4'd6, 16'h0100, 16'h0100, 1);
    issue(4'd6, 16'h0003, 16'h0005, 1);
    issue(4'd11, 16'h8001, 16'h0001, 1);
    issue(4'd9, 16'h1234, 16'hA5A0, 1);
    issue(4'd10, 16'h8001, 16'h000F, 1);
    issue(4'd0, 16'h7FFF, 16'h0001, 1);
    issue(4'd15, 16'h1234, 16'h5678, 1);

    // Backpressure: held result, in_valid ignored while DONE.
    @(negedge clk);
    bp_mode = 2;
    out_ready = 1'b0;
    issue(4'd4, 16'hF0F0, 16'h0FF0, 1);
    e = q[q.size()-1];
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      instr[7:4] = 4'd0;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_x", x, e.x);
      check("bp_code", code, e.code);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Reset in the middle of a multiply (or while a held result sits in DONE).
    out_ready = 1'b0;
    issue(4'd6, 16'h00FF, 16'h00FF, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_code", code, 0);
    check("arst_x", x, 0);
    model_code = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    bp_mode = 0;

    // Randomized mix with random backpressure.
    bp_mode = 1;
    repeat (120) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom());
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom());
      issue(4'($urandom()), ra, rb, 1);
    end

    // Drain.
    @(negedge clk);
    bp_mode = 0;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
